// File: rtl/inst_sram_responder.sv
// SRAM-like req/addr_ok/data_ok responder backed by a word RAM.
// Fixed-latency, in-order responses with a bounded number of outstanding requests.
module inst_sram_responder #(
    parameter logic [31:0] ADDR_BASE       = 32'h1c00_0000,
    parameter int          MEM_WORDS       = 1024,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter              INIT_FILE       = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    input  logic        stall_i,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0] mem [MEM_WORDS];

    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [LATENCY-1:0][31:0] dat_q, dat_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [31:0]      rd_word;
    logic             unused_ok;

    assign off      = sram_addr - ADDR_BASE;
    assign in_range = (sram_addr >= ADDR_BASE) && (off[31:2] < 30'(MEM_WORDS));
    assign idx      = off[IDX_W+1:2];
    assign unused_ok = ^{sram_size, off[1:0]};

    // A slot retiring this cycle frees room for a same-cycle accept.
    assign sram_addr_ok = !rst && sram_req && !stall_i &&
                          ((int'(cnt_q) - int'(sram_data_ok)) < MAX_OUTSTANDING);
    assign accept = sram_req && sram_addr_ok;

    assign rd_word = (!sram_wr && in_range) ? mem[idx] : 32'h0;

    assign sram_data_ok = vld_q[LATENCY-1];
    assign sram_rdata   = dat_q[LATENCY-1];

    // Data stages only load behind a valid entry, so the last stage holds rdata across bubbles.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = accept;
        if (accept) dat_d[0] = rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
        end
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(sram_data_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    // RAM is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && sram_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wstrb[b]) mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end
endmodule
